// File: rtl/edge_window_ctrl.sv
// Frame sequencer for the 3x3 edge-detection kernel: tracks rows, rotates the line-buffer
// write select and flags window centres. Optional eol/column check under EDGE_WINDOW_SYNC_CHECK_EN.
module edge_window_ctrl #(
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pix_valid,
    input  logic [COL_BITS-1:0] col_idx,
    input  logic                eol,
    output logic [1:0]          lb_wr_sel,
    output logic                win_valid,
    output logic [ROW_BITS-1:0] win_row,
    output logic [COL_BITS-1:0] win_col,
    output logic                busy,
    output logic                frame_done,
    output logic                sync_err
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT);
    localparam logic [COL_BITS-1:0] MIN_COL  = COL_BITS'(3);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

    state_t              state;
    logic [ROW_BITS-1:0] row;
    logic                streaming;
    logic                row_end;
    logic                win_hit;

    assign streaming = (state == FILL) || (state == ACTIVE);
    assign row_end   = streaming && pix_valid && eol;
    // out-of-range columns (0 or beyond the row) never produce a window
    assign win_hit   = (state == ACTIVE) && pix_valid &&
                       (col_idx >= MIN_COL) && (col_idx <= LAST_COL);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= ROW_BITS'(1);
            lb_wr_sel  <= 2'd0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_hit;
            frame_done <= 1'b0;
            if (win_hit) begin
                win_row <= row - ROW_BITS'(1);
                win_col <= col_idx - COL_BITS'(1);
            end
            if (row_end)
                lb_wr_sel <= (lb_wr_sel == 2'd2) ? 2'd0 : lb_wr_sel + 2'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        row       <= ROW_BITS'(1);
                        lb_wr_sel <= 2'd0;
                    end
                end
                FILL: begin
                    if (row_end) begin
                        row <= row + ROW_BITS'(1);
                        if (row == ROW_BITS'(2))
                            state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // row saturates at the last line; the final eol closes the frame
                    if (row_end) begin
                        if (row == LAST_ROW) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            row <= row + ROW_BITS'(1);
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EDGE_WINDOW_SYNC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_err <= 1'b0;
        else if ((state == IDLE) && start)
            sync_err <= 1'b0;
        else if (streaming && pix_valid && (eol != (col_idx == LAST_COL)))
            sync_err <= 1'b1;
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Directed bench for edge_window_ctrl on a 5x4 image: table-driven full frame plus
// hand-written stall, start, reset and sync-check sequences.
module tb_edge_window_ctrl;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] col_idx = '0;
    logic       eol = 1'b0;
    logic [1:0] lb_wr_sel;
    logic       win_valid;
    logic [9:0] win_row;
    logic [9:0] win_col;
    logic       busy;
    logic       frame_done;
    logic       sync_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [19:0] wq[$];

    edge_window_ctrl #(.COL_BITS(10), .ROW_BITS(10), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .col_idx(col_idx),
        .eol(eol), .lb_wr_sel(lb_wr_sel), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid === 1'b1) wq.push_back({win_row, win_col});
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    typedef struct {
        logic       st;
        logic       pv;
        int         col;
        logic       e;
        int         wv;
        int         wr;
        int         wc;
        int         sel;
        int         bsy;
        int         fd;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int c, input bit e, input int stall_pct, input bit st);
        while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
            pix_valid = 1'b0; start = st;
            cyc();
        end
        pix_valid = 1'b1; col_idx = 10'(c); eol = e; start = st;
        cyc();
        pix_valid = 1'b0; eol = 1'b0; start = 1'b0;
    endtask

    task automatic begin_frame();
        wq.delete();
        done_cnt = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic stream_rows(input int r0, input int stall_pct, input bit junk_start);
        for (int r = r0; r <= H; r++)
            for (int c = 1; c <= W; c++)
                pix(c, c == W, stall_pct, junk_start);
    endtask

    task automatic check_frame(input string nm);
        for (int i = 0; i < 3; i++) cyc();
        chk({nm, ".win_count"}, wq.size(), 6);
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            chk({nm, ".win_row"}, int'(wq[i][19:10]), 2 + i / 3);
            chk({nm, ".win_col"}, int'(wq[i][9:0]), 2 + i % 3);
        end
        chk({nm, ".done_count"}, done_cnt, 1);
        chk({nm, ".busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int lr, lc, k;
        // expected outputs one cycle after each applied vector
        tbl[0] = '{st:1, pv:0, col:0, e:0, wv:0, wr:0, wc:0, sel:0, bsy:1, fd:0};
        lr = 0; lc = 0;
        for (int r = 1; r <= H; r++) begin
            for (int c = 1; c <= W; c++) begin
                k = 1 + (r - 1) * W + (c - 1);
                if (r >= 3 && c >= 3) begin lr = r - 1; lc = c - 1; end
                tbl[k] = '{st:0, pv:1, col:c, e:(c == W), wv:(r >= 3 && c >= 3), wr:lr, wc:lc,
                           sel:((c == W) ? r % 3 : (r - 1) % 3), bsy:1, fd:(r == H && c == W)};
            end
        end
        tbl[21] = '{st:0, pv:0, col:0, e:0, wv:0, wr:lr, wc:lc, sel:H % 3, bsy:0, fd:0};

        #3;
        chk("reset.lb_wr_sel", int'(lb_wr_sel), 0);
        chk("reset.win_valid", int'(win_valid), 0);
        chk("reset.win_row", int'(win_row), 0);
        chk("reset.win_col", int'(win_col), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.frame_done", int'(frame_done), 0);
        chk("reset.sync_err", int'(sync_err), 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // back-to-back full frame, every output checked each cycle
        for (int i = 0; i < 22; i++) begin
            start = tbl[i].st; pix_valid = tbl[i].pv; col_idx = 10'(tbl[i].col); eol = tbl[i].e;
            cyc();
            chk($sformatf("tbl%0d.win_valid", i), int'(win_valid), tbl[i].wv);
            chk($sformatf("tbl%0d.win_row", i), int'(win_row), tbl[i].wr);
            chk($sformatf("tbl%0d.win_col", i), int'(win_col), tbl[i].wc);
            chk($sformatf("tbl%0d.lb_wr_sel", i), int'(lb_wr_sel), tbl[i].sel);
            chk($sformatf("tbl%0d.busy", i), int'(busy), tbl[i].bsy);
            chk($sformatf("tbl%0d.frame_done", i), int'(frame_done), tbl[i].fd);
            chk($sformatf("tbl%0d.sync_err", i), int'(sync_err), 0);
        end
        start = 1'b0; pix_valid = 1'b0; eol = 1'b0;
        cyc();

        // 50% stalls, with junk start asserted throughout the stream
        begin_frame();
        stream_rows(1, 50, 1'b1);
        check_frame("stall");

        // start coinciding with an eol pixel in IDLE must not consume that pixel
        wq.delete(); done_cnt = 0;
        start = 1'b1; pix_valid = 1'b1; col_idx = 10'(W); eol = 1'b1;
        cyc();
        start = 1'b0; pix_valid = 1'b0; eol = 1'b0;
        chk("startpix.row_sel", int'(lb_wr_sel), 0);
        stream_rows(1, 0, 1'b0);
        check_frame("startpix");

        // reset during row 3 discards the frame without frame_done
        begin_frame();
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= W; c++) pix(c, c == W, 0, 1'b0);
        for (int c = 1; c <= 3; c++) pix(c, 1'b0, 0, 1'b0);
        chk("midrst.pre_win_row", int'(win_row), 2);
        rst = 1'b1;
        #2;
        chk("midrst.lb_wr_sel", int'(lb_wr_sel), 0);
        chk("midrst.win_valid", int'(win_valid), 0);
        chk("midrst.win_row", int'(win_row), 0);
        chk("midrst.win_col", int'(win_col), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.frame_done", int'(frame_done), 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("midrst.no_done", done_cnt, 0);
        chk("midrst.idle", int'(busy), 0);
        begin_frame();
        stream_rows(1, 0, 1'b0);
        check_frame("postrst");

        // early eol at column 3: row still advances, sync_err latches when enabled
        begin_frame();
        pix(1, 1'b0, 0, 1'b0);
        pix(2, 1'b0, 0, 1'b0);
        chk("sync.before", int'(sync_err), 0);
        pix(3, 1'b1, 0, 1'b0);
`ifdef EDGE_WINDOW_SYNC_CHECK_EN
        chk("sync.set", int'(sync_err), 1);
`else
        chk("sync.tied", int'(sync_err), 0);
`endif
        stream_rows(2, 0, 1'b0);
        check_frame("sync");
`ifdef EDGE_WINDOW_SYNC_CHECK_EN
        chk("sync.held", int'(sync_err), 1);
`else
        chk("sync.held_zero", int'(sync_err), 0);
`endif
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("sync.cleared", int'(sync_err), 0);
        chk("sync.restart_busy", int'(busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
